// File: rtl/intc_prio_vec.sv
// Parametrised interrupt controller: per-channel ISR vectors, mask, pending, priority arbitration, IRQ/IACK handshake.
// Optional rotating priority when INTC_ROUND_ROBIN_EN is defined; fixed highest-index priority otherwise.
module intc_prio_vec #(
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         done,
   input  logic                      IACK,
   input  logic [31:0]               input_addr,
   input  logic                      write_enable,
   input  logic [DATA_W-1:0]         write_data,
   output logic [DATA_W-1:0]         read_data,
   output logic                      IRQ,
   output logic [DATA_W-1:0]         isr_addr,
   output logic [$clog2(NUM_CH)-1:0] irq_id,
   output logic                      error
);

   localparam int unsigned ID_W = $clog2(NUM_CH);
   localparam int unsigned WA_W = 30;
   localparam logic [WA_W-1:0] BASE_WA  = BASE_ADDR[31:2];
   localparam logic [WA_W-1:0] OFS_PEND = WA_W'(32'h40);
   localparam logic [WA_W-1:0] OFS_MASK = WA_W'(32'h41);
   localparam logic [WA_W-1:0] OFS_STAT = WA_W'(32'h42);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACKW = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   vec_q [NUM_CH];
   logic [DATA_W-1:0]   vec_d [NUM_CH];
   logic [NUM_CH-1:0]   pending_q, pending_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic                irq_q, irq_d;
   logic [DATA_W-1:0]   isr_addr_q, isr_addr_d;
   logic [ID_W-1:0]     irq_id_q, irq_id_d;
   logic                error_q, error_d;
`ifdef INTC_ROUND_ROBIN_EN
   logic [ID_W-1:0]     last_q, last_d;
   logic [ID_W-1:0]     cand;
`endif

   logic [WA_W-1:0]     ofs;
   logic                vec_hit, pend_hit, mask_hit, stat_hit;
   logic [ID_W-1:0]     vec_sel;
   logic [NUM_CH-1:0]   eligible;
   logic [ID_W-1:0]     win;
   logic [NUM_CH-1:0]   clr;
   logic                iack_idle;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^input_addr[1:0];

   // Word-offset decode relative to the block base; wraps below base so it never hits.
   always_comb begin
      ofs      = input_addr[31:2] - BASE_WA;
      vec_hit  = (ofs < WA_W'(NUM_CH));
      vec_sel  = ID_W'(ofs);
      pend_hit = (ofs == OFS_PEND);
      mask_hit = (ofs == OFS_MASK);
      stat_hit = (ofs == OFS_STAT);
   end

   always_comb begin
      read_data = '0;
      if (vec_hit)       read_data = vec_q[vec_sel];
      else if (pend_hit) read_data = DATA_W'(pending_q);
      else if (mask_hit) read_data = DATA_W'(mask_q);
      else if (stat_hit) read_data = DATA_W'({error_q, state_q, irq_id_q});
   end

   // Winner among pending & enabled channels.
   always_comb begin
      eligible = pending_q & mask_q;
      win      = '0;
`ifdef INTC_ROUND_ROBIN_EN
      cand     = '0;
      // Smallest rotation distance from last_served+1 wins, so it is assigned last.
      for (int unsigned k = NUM_CH; k > 0; k--) begin
         cand = ID_W'((32'(last_q) + k) % NUM_CH);
         if (eligible[cand]) win = cand;
      end
`else
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (eligible[ID_W'(i)]) win = ID_W'(i);
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      mask_d     = mask_q;
      irq_d      = irq_q;
      isr_addr_d = isr_addr_q;
      irq_id_d   = irq_id_q;
      clr        = '0;
      iack_idle  = 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
      last_d     = last_q;
`endif

      if (write_enable && vec_hit)  vec_d[vec_sel] = write_data;
      if (write_enable && mask_hit) mask_d = NUM_CH'(write_data);
      if (write_enable && pend_hit) clr = NUM_CH'(write_data);

      case (state_q)
         ST_IDLE: begin
            iack_idle = IACK;
            if (|eligible) begin
               irq_d      = 1'b1;
               irq_id_d   = win;
               isr_addr_d = vec_q[win];
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (IACK) begin
               clr[irq_id_q] = 1'b1;
               irq_d         = 1'b0;
               state_d       = ST_ACKW;
`ifdef INTC_ROUND_ROBIN_EN
               last_d        = irq_id_q;
`endif
            end
         end
         ST_ACKW: begin
            if (!IACK) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A new done pulse always wins over any clear of the same bit.
      pending_d = (pending_q & ~clr) | done;
      error_d   = (error_q & ~(write_enable && stat_hit)) | (|(done & pending_q)) | iack_idle;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         for (int unsigned i = 0; i < NUM_CH; i++) vec_q[i] <= '0;
         pending_q  <= '0;
         mask_q     <= '1;
         irq_q      <= 1'b0;
         isr_addr_q <= '0;
         irq_id_q   <= '0;
         error_q    <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
         last_q     <= ID_W'(NUM_CH - 1);
`endif
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         irq_q      <= irq_d;
         isr_addr_q <= isr_addr_d;
         irq_id_q   <= irq_id_d;
         error_q    <= error_d;
`ifdef INTC_ROUND_ROBIN_EN
         last_q     <= last_d;
`endif
      end
   end

   assign IRQ      = irq_q;
   assign isr_addr = isr_addr_q;
   assign irq_id   = irq_id_q;
   assign error    = error_q;

endmodule

// File: tb/tb_intc_prio_vec.sv
// Scoreboard bench for intc_prio_vec: expected reads, IRQ vectors and state probes are queued by the
// stimulus and consumed by independent monitors.
module tb_intc_prio_vec;
   localparam int unsigned NUM_CH = 8;
   localparam int unsigned DATA_W = 32;
   localparam logic [31:0] BASE   = 32'h0000_2000;
   localparam logic [31:0] A_PEND = BASE + 32'h100;
   localparam logic [31:0] A_MASK = BASE + 32'h104;
   localparam logic [31:0] A_STAT = BASE + 32'h108;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NUM_CH-1:0] done = '0;
   logic              IACK = 1'b0;
   logic [31:0]       input_addr = '0;
   logic              write_enable = 1'b0;
   logic [DATA_W-1:0] write_data = '0;
   logic [DATA_W-1:0] read_data;
   logic              IRQ;
   logic [DATA_W-1:0] isr_addr;
   logic [2:0]        irq_id;
   logic              error;

   intc_prio_vec #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .done(done), .IACK(IACK), .input_addr(input_addr),
      .write_enable(write_enable), .write_data(write_data), .read_data(read_data),
      .IRQ(IRQ), .isr_addr(isr_addr), .irq_id(irq_id), .error(error));

   always #5 clk = ~clk;

   typedef struct { logic [31:0] isr; logic [2:0] id; int lat; } irq_exp_t;
   typedef struct { logic irq; logic err; logic chk_vec; logic [31:0] isr; logic [2:0] id; } probe_t;

   irq_exp_t    irq_q[$];
   probe_t      probe_q[$];
   logic [31:0] rd_exp_q[$];
   logic [31:0] rd_addr_q[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   mark = 0;
   logic rd_valid = 1'b0;
   logic irq_prev = 1'b0;
   event probe_ev;

   logic [31:0] m_e, m_a;
   irq_exp_t    m_i;
   probe_t      m_p;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-data and IRQ-rise monitor.
   always @(negedge clk) begin
      if (rd_valid) begin
         checks++;
         if (rd_exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected addr=%h got=%h", input_addr, read_data);
         end else begin
            m_e = rd_exp_q.pop_front();
            m_a = rd_addr_q.pop_front();
            if (read_data !== m_e) begin
               errors++;
               $display("FAIL rd_%h got=%h exp=%h", m_a, read_data, m_e);
            end
         end
      end
      if (IRQ === 1'b1 && irq_prev === 1'b0) begin
         checks++;
         if (irq_q.size() == 0) begin
            errors++;
            $display("FAIL irq_unexpected got isr=%h id=%0d", isr_addr, irq_id);
         end else begin
            m_i = irq_q.pop_front();
            if (isr_addr !== m_i.isr || irq_id !== m_i.id ||
                (m_i.lat >= 0 && (cyc - mark) != m_i.lat)) begin
               errors++;
               $display("FAIL irq_vec got isr=%h id=%0d lat=%0d exp isr=%h id=%0d lat=%0d",
                        isr_addr, irq_id, cyc - mark, m_i.isr, m_i.id, m_i.lat);
            end
         end
      end
      irq_prev = IRQ;
   end

   // Asynchronous state probe monitor.
   always @(probe_ev) begin
      #1;
      checks++;
      if (probe_q.size() == 0) begin
         errors++;
         $display("FAIL probe_unexpected");
      end else begin
         m_p = probe_q.pop_front();
         if (IRQ !== m_p.irq || error !== m_p.err ||
             (m_p.chk_vec && (isr_addr !== m_p.isr || irq_id !== m_p.id))) begin
            errors++;
            $display("FAIL probe got irq=%b err=%b isr=%h id=%0d exp irq=%b err=%b isr=%h id=%0d",
                     IRQ, error, isr_addr, irq_id, m_p.irq, m_p.err, m_p.isr, m_p.id);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      input_addr   = a;
      write_data   = d;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
      rd_exp_q.push_back(e);
      rd_addr_q.push_back(a);
      input_addr = a;
      rd_valid   = 1'b1;
      tick();
      rd_valid   = 1'b0;
   endtask

   task automatic pulse_done(input logic [NUM_CH-1:0] v);
      done = v;
      mark = cyc;
      tick();
      done = '0;
   endtask

   task automatic iack();
      IACK = 1'b1;
      tick();
      IACK = 1'b0;
      tick();
   endtask

   task automatic wait_irq();
      int n;
      n = 0;
      while (IRQ !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (IRQ !== 1'b1) begin
         errors++;
         $display("FAIL irq_timeout got=%b exp=1", IRQ);
      end
      tick();
   endtask

   task automatic push_irq(input logic [31:0] isr, input logic [2:0] id, input int lat);
      irq_exp_t r;
      r.isr = isr;
      r.id  = id;
      r.lat = lat;
      irq_q.push_back(r);
   endtask

   task automatic probe(input logic i, input logic e, input logic cv, input logic [31:0] isr,
                        input logic [2:0] id);
      probe_t p;
      p.irq = i; p.err = e; p.chk_vec = cv; p.isr = isr; p.id = id;
      probe_q.push_back(p);
      ->probe_ev;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      // Reset state
      probe(1'b0, 1'b0, 1'b1, 32'h0, 3'd0);
      bus_read(A_PEND, 32'h0);
      bus_read(A_MASK, 32'hFF);
      bus_read(A_STAT, 32'h0);
      bus_read(BASE, 32'h0);
      rst = 1'b1;
      tick();

      // Vector table and unmapped accesses
      bus_write(BASE + 32'h0, 32'hA);
      bus_write(BASE + 32'h4, 32'hB);
      bus_write(BASE + 32'h8, 32'hC);
      bus_write(BASE + 32'hC, 32'hD);
      bus_write(BASE + 32'h1C, 32'h77);
      bus_write(BASE + 32'h200, 32'hDEAD);
      bus_write(BASE + 32'h20, 32'hBEEF);
      bus_read(BASE + 32'h0, 32'hA);
      bus_read(BASE + 32'h4, 32'hB);
      bus_read(BASE + 32'h8, 32'hC);
      bus_read(BASE + 32'hD, 32'hD);
      bus_read(BASE + 32'h1C, 32'h77);
      bus_read(BASE + 32'h200, 32'h0);
      bus_read(BASE + 32'h20, 32'h0);

      // Single interrupt, two-clock latency
      push_irq(32'hD, 3'd3, 2);
      pulse_done(8'h08);
      bus_read(A_PEND, 32'h08);
      wait_irq();
      bus_read(A_STAT, 32'h0B);
      iack();
      probe(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
      bus_read(A_PEND, 32'h0);

`ifndef INTC_ROUND_ROBIN_EN
      // Fixed priority: ch2 before ch0
      push_irq(32'hC, 3'd2, 2);
      push_irq(32'hA, 3'd0, -1);
      pulse_done(8'h05);
      wait_irq();
      iack();
      wait_irq();
      iack();
      tick();
      tick();
      probe(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
      bus_read(A_PEND, 32'h0);
`endif

      // Set beats a simultaneous W1C
      push_irq(32'hB, 3'd1, -1);
      done = 8'h02; input_addr = A_PEND; write_data = 32'h2; write_enable = 1'b1;
      tick();
      done = '0; write_enable = 1'b0;
      wait_irq();
      iack();

      // Masked pending, overrun, error clear
      bus_write(A_MASK, 32'hFE);
      pulse_done(8'h01);
      tick();
      tick();
      probe(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
      bus_read(A_PEND, 32'h01);
      push_irq(32'hA, 3'd0, -1);
      bus_write(A_MASK, 32'hFF);
      wait_irq();
      pulse_done(8'h01);
      probe(1'b1, 1'b1, 1'b1, 32'hA, 3'd0);
      bus_read(A_STAT, 32'h28);
      iack();
      bus_write(A_STAT, 32'h0);
      bus_read(A_STAT, 32'h0);
      bus_read(A_PEND, 32'h0);

      // IACK while idle
      IACK = 1'b1;
      tick();
      IACK = 1'b0;
      tick();
      probe(1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
      bus_read(A_STAT, 32'h20);
      bus_write(A_STAT, 32'h0);
      bus_read(A_STAT, 32'h0);

      // In-service vector frozen against new pending, VEC write, mask and W1C
      push_irq(32'hD, 3'd3, 2);
      pulse_done(8'h08);
      wait_irq();
      pulse_done(8'h80);
      bus_write(BASE + 32'hC, 32'h99);
      bus_write(A_MASK, 32'hF7);
      probe(1'b1, 1'b0, 1'b1, 32'hD, 3'd3);
      bus_write(A_PEND, 32'h08);
      bus_read(A_PEND, 32'h80);
      push_irq(32'h77, 3'd7, -1);
      iack();
      wait_irq();
      iack();
      bus_write(A_MASK, 32'hFF);
      bus_write(BASE + 32'hC, 32'hD);
      bus_read(A_PEND, 32'h0);

      // Asynchronous reset in REQ with error set
      push_irq(32'hD, 3'd3, 2);
      pulse_done(8'h08);
      wait_irq();
      pulse_done(8'h08);
      probe(1'b1, 1'b1, 1'b1, 32'hD, 3'd3);
      tick();
      rst = 1'b0;
      probe(1'b0, 1'b0, 1'b1, 32'h0, 3'd0);
      bus_read(A_PEND, 32'h0);
      bus_read(BASE + 32'hC, 32'h0);
      bus_read(A_MASK, 32'hFF);
      rst = 1'b1;
      tick();

`ifdef INTC_ROUND_ROBIN_EN
      // Rotating priority from ch0
      for (int i = 0; i < 8; i++) bus_write(BASE + 32'(4 * i), 32'hA0 + 32'(i));
      for (int i = 0; i < 8; i++) push_irq(32'hA0 + 32'(i), 3'(i), -1);
      pulse_done(8'hFF);
      for (int i = 0; i < 8; i++) begin
         wait_irq();
         iack();
      end
      push_irq(32'hA0, 3'd0, -1);
      push_irq(32'hA7, 3'd7, -1);
      pulse_done(8'h81);
      wait_irq();
      iack();
      wait_irq();
      iack();
`endif

      repeat (4) tick();
      probe(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
      tick();
      checks++;
      if (irq_q.size() != 0) begin
         errors++;
         $display("FAIL irq_missing got=%0d left exp=0", irq_q.size());
      end
      checks++;
      if (rd_exp_q.size() != 0 || probe_q.size() != 0) begin
         errors++;
         $display("FAIL queue_left got rd=%0d probe=%0d exp=0", rd_exp_q.size(), probe_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/intc_prio_vec.md
Name: intc_prio_vec

Overview:
- Parametrised successor to the 4-channel interrupt controller: NUM_CH done sources, per-channel ISR vector table, mask register, pending register, registered priority arbitration and an IRQ/IACK handshake FSM.
- Sits between the factorial accelerator array and the MIPS core, on the memory-mapped bus at BASE_ADDR.
- Presents IRQ plus the vector of the winning channel; retires that channel on IACK.

Parameters:
- NUM_CH, 8, number of interrupt sources (2..32).
- DATA_W, 32, bus data width and ISR vector width.
- BASE_ADDR, 32'h00002000, base of the register block.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- done  in  NUM_CH  per-channel completion pulse, level-sampled each clock.
- IACK  in  1  interrupt acknowledge from the core.
- input_addr  in  32  bus address.
- write_enable  in  1  bus write strobe.
- write_data  in  DATA_W  bus write data.
- read_data  out  DATA_W  combinational read of the addressed register; 0 when unmapped.
- IRQ  out  1  interrupt request, registered.
- isr_addr  out  DATA_W  vector of the in-service channel, registered.
- irq_id  out  $clog2(NUM_CH)  index of the in-service channel.
- error  out  1  sticky error flag.

Behaviour:
- Register map (word aligned; input_addr[1:0] ignored):
  - BASE+4*i: VEC[i], read/write.
  - BASE+0x100: PENDING, read; write-1-to-clear.
  - BASE+0x104: MASK, read/write; 1 = enabled.
  - BASE+0x108: STATUS = {error, state, irq_id}; any write clears error.
- Unmapped writes are ignored.
- Reset (rst=0, async):
  - VEC=0, PENDING=0, MASK=all ones, error=0.
  - IRQ=0, isr_addr=0, irq_id=0, state=IDLE.
- Pending: done[i]=1 at edge k sets PENDING[i] at edge k.
  - Set beats a simultaneous W1C or IACK-clear of the same bit.
- Overrun: done[i]=1 while PENDING[i] already 1 sets error. PENDING[i] stays 1 and no event is counted.
- Eligible set = PENDING & MASK. Arbitration is fixed priority: highest index wins.
- FSM:
  - IDLE: if eligible is non-zero at edge k, latch irq_id and isr_addr=VEC[irq_id], set IRQ=1, go to REQ. IRQ is therefore visible after edge k+1 relative to done; minimum done-to-IRQ latency is 2 clocks.
  - REQ: IRQ held; irq_id and isr_addr frozen even if a higher channel becomes pending. On IACK=1: clear PENDING[irq_id], IRQ=0, go to ACKW.
  - ACKW: wait for IACK=0, then go to IDLE. The next arbitration happens no earlier than the following edge.
- Masking a channel while it is in REQ does not withdraw IRQ.
- A VEC[irq_id] write during REQ does not change isr_addr.
- IACK=1 in IDLE sets error; no state change.
- A W1C of the in-service bit during REQ clears it. IACK still completes normally.
- Writing MASK=0 with pending bits: IRQ is not asserted; the bits stay pending until unmasked.

Optional Feature:
- INTC_ROUND_ROBIN_EN defined: rotating priority.
  - Search starts at (last_served+1) mod NUM_CH, wrapping around.
  - last_served updates on IACK; reset value is NUM_CH-1, so ch0 has top priority first.
- Undefined: fixed highest-index priority as above.

Test Plan:
- Table write/readback: write VEC[0..3]=0xA..0xD at 0x2000..0x200C, VEC[7]=0x77 at 0x201C -> read_data returns each value; a read at 0x2200 returns 0.
- Single interrupt: done=0x08 for 1 clock -> PENDING=0x08, IRQ=1 two clocks later, isr_addr=0xD, irq_id=3. IACK 1 clock -> IRQ=0, PENDING=0.
- Priority: done=0x05 in one cycle -> ch2 served first (isr_addr=0xC). After IACK/release -> ch0 (isr_addr=0xA), then IRQ stays 0.
- Mask/overrun:
  - MASK=0xFE, done=0x01 -> no IRQ, PENDING=0x01; write MASK=0xFF -> IRQ with isr_addr=0xA.
  - Second done[0] before IACK -> error=1. Write STATUS -> error=0.
  - IACK in IDLE -> error=1.
- Reset mid-operation: rst=0 while in REQ -> IRQ, isr_addr, PENDING and error go to 0 immediately, without a clock edge; VEC reads return 0.
- INTC_ROUND_ROBIN_EN: done=0xFF held pending -> service order ch0, ch1, …, ch7 with matching vectors. Re-assert 0x81 -> ch0 served before ch7.
